// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the coordinate type used by the timing
// generator and by every renderer doing address math on DrawX/DrawY.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned CoordW = 10;

  typedef logic [CoordW-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis. Resets to the last position so the first
// enabled edge after reset lands on 0; exposes its next value for registering.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned Total = 800
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   wrap
);

  localparam coord_t Last = coord_t'(Total - 1);

  coord_t count_q;

  always_comb begin
    wrap       = en && (count_q == Last);
    count_next = count_q;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= Last;
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: registered, mutually aligned DrawX/DrawY,
// syncs, blank and line/frame pulses. Define VGA_BLINK_EN for the blink toggle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic                vga_clk,
  input  logic                reset,
  output logic                hs,
  output logic                vs,
  output logic                blank,
  output vga_pkg::coord_t     DrawX,
  output vga_pkg::coord_t     DrawY,
  output logic                line_start,
  output logic                frame_start,
  output logic                blink
);

  import vga_pkg::*;

  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTot > 1024 || VTot > 1024) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t HActive    = coord_t'(H_ACTIVE);
  localparam coord_t HSyncStart = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HSyncEnd   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VActive    = coord_t'(V_ACTIVE);
  localparam coord_t VSyncStart = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VSyncEnd   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h_next, v_next;
  logic   h_wrap, v_wrap;

  vga_axis_counter #(
    .Total(HTot)
  ) u_h_counter (
    .clk       (vga_clk),
    .reset     (reset),
    .en        (1'b1),
    .count     (DrawX),
    .count_next(h_next),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .Total(VTot)
  ) u_v_counter (
    .clk       (vga_clk),
    .reset     (reset),
    .en        (h_wrap),
    .count     (DrawY),
    .count_next(v_next),
    .wrap      (v_wrap)
  );

  logic hs_d, vs_d, blank_d, line_start_d, frame_start_d;
  logic hs_q, vs_q, blank_q, line_start_q, frame_start_q;

  // Decode from next-state counters so registered flags match the registered coordinates.
  always_comb begin
    hs_d          = !((h_next >= HSyncStart) && (h_next < HSyncEnd));
    vs_d          = !((v_next >= VSyncStart) && (v_next < VSyncEnd));
    blank_d       = (h_next < HActive) && (v_next < VActive);
    line_start_d  = (h_next == '0);
    frame_start_d = line_start_d && (v_next == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_BLINK_EN
  logic [4:0] frame_cnt_q;
  logic       blink_q;

  // Toggle on the 31 -> 0 wrap: one blink phase per 32 frames.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
      if (&frame_cnt_q) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line-level timing and a
// shrunken-raster instance for frame-level and blink behaviour.
module tb_vga_timing_gen;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;  // 25
  localparam int SVT = SVA + SVF + SVS + SVB;  // 19

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f, rst_s;
  logic       f_hs, f_vs, f_blank, f_ls, f_fs, f_blink;
  logic [9:0] f_x, f_y;
  logic       s_hs, s_vs, s_blank, s_ls, s_fs, s_blink;
  logic [9:0] s_x, s_y;

  vga_timing_gen u_dut_full (
    .vga_clk    (clk),
    .reset      (rst_f),
    .hs         (f_hs),
    .vs         (f_vs),
    .blank      (f_blank),
    .DrawX      (f_x),
    .DrawY      (f_y),
    .line_start (f_ls),
    .frame_start(f_fs),
    .blink      (f_blink)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_dut_small (
    .vga_clk    (clk),
    .reset      (rst_s),
    .hs         (s_hs),
    .vs         (s_vs),
    .blank      (s_blank),
    .DrawX      (s_x),
    .DrawY      (s_y),
    .line_start (s_ls),
    .frame_start(s_fs),
    .blink      (s_blink)
  );

  typedef struct {
    int x;
    int y;
    int fc;
    bit bl;
  } mstate_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs, vs, blank, ls, fs, blink;
  } exp_t;

  int      errors = 0;
  int      checks = 0;
  exp_t    qf[$];
  exp_t    qs[$];
  mstate_t mf = '{x: 0, y: 0, fc: 0, bl: 1'b0};
  mstate_t ms = '{x: 0, y: 0, fc: 0, bl: 1'b0};

  // Reference raster model written from the timing description.
  function automatic exp_t step_model(input int ha, input int hf, input int hsw, input int hb,
                                      input int va, input int vf, input int vsw, input int vb,
                                      input bit r, inout mstate_t s);
    exp_t e;
    int   ht = ha + hf + hsw + hb;
    int   vt = va + vf + vsw + vb;
    if (r) begin
      s.x = ht - 1; s.y = vt - 1; s.fc = 0; s.bl = 1'b0;
    end else if (s.x == ht - 1) begin
      s.x = 0;
      s.y = (s.y == vt - 1) ? 0 : s.y + 1;
    end else begin
      s.x = s.x + 1;
    end
    e.x     = s.x[9:0];
    e.y     = s.y[9:0];
    e.hs    = !(s.x >= ha + hf && s.x < ha + hf + hsw);
    e.vs    = !(s.y >= va + vf && s.y < va + vf + vsw);
    e.blank = (s.x < ha) && (s.y < va);
    e.ls    = !r && (s.x == 0);
    e.fs    = e.ls && (s.y == 0);
`ifdef VGA_BLINK_EN
    if (e.fs) begin
      if (s.fc == 31) s.bl = ~s.bl;
      s.fc = (s.fc + 1) % 32;
    end
`endif
    e.blink = s.bl;
    return e;
  endfunction

  task automatic tick(input bit rf, input bit rs);
    rst_f = rf;
    rst_s = rs;
    qf.push_back(step_model(640, 16, 96, 48, 480, 10, 2, 33, rf, mf));
    qs.push_back(step_model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, rs, ms));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop the expectation pushed for the edge just taken.
  always @(negedge clk) begin
    exp_t e;
    if (qf.size() > 0) begin
      e = qf.pop_front();
      checks++;
      if ({f_x, f_y, f_hs, f_vs, f_blank, f_ls, f_fs, f_blink} !==
          {e.x, e.y, e.hs, e.vs, e.blank, e.ls, e.fs, e.blink}) begin
        errors++;
        $display("FAIL sb_full: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b bk=%b, want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b bk=%b",
                 f_x, f_y, f_hs, f_vs, f_blank, f_ls, f_fs, f_blink,
                 e.x, e.y, e.hs, e.vs, e.blank, e.ls, e.fs, e.blink);
      end
      checks++;
      if (f_blank !== (f_x < 10'd640 && f_y < 10'd480) || (f_fs === 1'b1 && f_ls !== 1'b1)) begin
        errors++;
        $display("FAIL inv_full: x=%0d y=%0d blank=%b ls=%b fs=%b", f_x, f_y, f_blank, f_ls, f_fs);
      end
    end
    if (qs.size() > 0) begin
      e = qs.pop_front();
      checks++;
      if ({s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_blink} !==
          {e.x, e.y, e.hs, e.vs, e.blank, e.ls, e.fs, e.blink}) begin
        errors++;
        $display("FAIL sb_small: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b bk=%b, want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b bk=%b",
                 s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_blink,
                 e.x, e.y, e.hs, e.vs, e.blank, e.ls, e.fs, e.blink);
      end
      checks++;
      if (s_blank !== (s_x < 10'(SHA) && s_y < 10'(SVA)) || (s_fs === 1'b1 && s_ls !== 1'b1)) begin
        errors++;
        $display("FAIL inv_small: x=%0d y=%0d blank=%b ls=%b fs=%b", s_x, s_y, s_blank, s_ls, s_fs);
      end
    end
  end

  task automatic test_reset;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    checks++;
    if ({f_x, f_y, f_hs, f_vs, f_blank, f_ls, f_fs, f_blink} !== {10'd799, 10'd524, 6'b110000}) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b blink=%b, want 799/524 hs=1 vs=1 rest 0",
               f_x, f_y, f_hs, f_vs, f_blank, f_ls, f_fs, f_blink);
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({f_x, f_y, f_hs, f_vs, f_blank, f_ls, f_fs} !== {10'd0, 10'd0, 5'b11111}) begin
      errors++;
      $display("FAIL first_edge: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b, want 0/0 all flags 1",
               f_x, f_y, f_hs, f_vs, f_blank, f_ls, f_fs);
    end
  endtask

  task automatic test_line;
    int   fall_x = -1, hs_cnt = 0, hs_min = 9999, hs_max = -1;
    logic prev_blank = f_blank;
    for (int i = 0; i < 800; i++) begin
      tick(1'b0, 1'b0);
      if (prev_blank === 1'b1 && f_blank === 1'b0 && fall_x < 0) fall_x = int'(f_x);
      prev_blank = f_blank;
      if (f_hs === 1'b0) begin
        hs_cnt++;
        if (int'(f_x) < hs_min) hs_min = int'(f_x);
        if (int'(f_x) > hs_max) hs_max = int'(f_x);
      end
    end
    checks++;
    if (fall_x != 640) begin
      errors++;
      $display("FAIL blank_fall: got DrawX=%0d, want 640", fall_x);
    end
    checks++;
    if (hs_cnt != 96 || hs_min != 656 || hs_max != 751) begin
      errors++;
      $display("FAIL hs_window: got %0d cycles %0d..%0d, want 96 cycles 656..751", hs_cnt, hs_min, hs_max);
    end
    checks++;
    if ({f_x, f_y, f_ls, f_fs} !== {10'd0, 10'd1, 2'b10}) begin
      errors++;
      $display("FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b, want 0/1 ls=1 fs=0", f_x, f_y, f_ls, f_fs);
    end
  endtask

  task automatic test_mid_reset_full;
    bit found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1'b0, 1'b0);
      if (f_x === 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_x300: got DrawX=%0d, want 300 within 1000 cycles", f_x);
    end
    tick(1'b1, 1'b0);
    checks++;
    if ({f_x, f_y, f_blank, f_ls, f_fs} !== {10'd799, 10'd524, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset_full: got x=%0d y=%0d blank=%b, want 799/524 blank=0", f_x, f_y, f_blank);
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({f_x, f_y, f_fs} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_release_full: got x=%0d y=%0d fs=%b, want 0/0 fs=1", f_x, f_y, f_fs);
    end
  endtask

  task automatic test_frame;
    int last = 0, per1 = -1, per2 = -1, nfs = 0, vcnt = 0, vfx = -1, vfy = -1, bad_blank = 0;
    int px = -1, py = -1, wrap_from_x = -1, wrap_from_y = -1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    for (int c = 1; c <= 2 * SHT * SVT; c++) begin
      px = int'(s_x);
      py = int'(s_y);
      tick(1'b0, 1'b0);
      if (c <= SHT * SVT && s_vs === 1'b0) begin
        if (vcnt == 0) begin vfx = int'(s_x); vfy = int'(s_y); end
        vcnt++;
      end
      if (int'(s_y) >= SVA && s_blank !== 1'b0) bad_blank++;
      if (s_fs === 1'b1) begin
        nfs++;
        if (nfs == 1) begin per1 = c - last; wrap_from_x = px; wrap_from_y = py; end
        else per2 = c - last;
        last = c;
      end
    end
    checks++;
    if (per1 != SHT * SVT || per2 != SHT * SVT || nfs != 2) begin
      errors++;
      $display("FAIL frame_period: got %0d,%0d (%0d starts), want %0d twice", per1, per2, nfs, SHT * SVT);
    end
    checks++;
    if (vcnt != 2 * SHT || vfx != 0 || vfy != SVA + SVF) begin
      errors++;
      $display("FAIL vs_window: got %0d cycles from %0d/%0d, want %0d from 0/%0d",
               vcnt, vfx, vfy, 2 * SHT, SVA + SVF);
    end
    checks++;
    if (bad_blank != 0) begin
      errors++;
      $display("FAIL vblank: got %0d visible cycles in lines >= %0d, want 0", bad_blank, SVA);
    end
    checks++;
    if (wrap_from_x != SHT - 1 || wrap_from_y != SVT - 1) begin
      errors++;
      $display("FAIL frame_wrap: got from %0d/%0d, want %0d/%0d", wrap_from_x, wrap_from_y, SHT - 1, SVT - 1);
    end
  endtask

  task automatic test_mid_reset_small;
    bit found = 1'b0;
    for (int i = 0; i < 2 * SHT * SVT && !found; i++) begin
      tick(1'b0, 1'b0);
      if (s_x === 10'd10 && s_y === 10'd8) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_10_8: got %0d/%0d, want 10/8", s_x, s_y);
    end
    tick(1'b0, 1'b1);
    checks++;
    if ({s_x, s_y, s_blank} !== {10'(SHT - 1), 10'(SVT - 1), 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_small: got x=%0d y=%0d blank=%b, want %0d/%0d blank=0",
               s_x, s_y, s_blank, SHT - 1, SVT - 1);
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({s_x, s_y, s_fs} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_release_small: got x=%0d y=%0d fs=%b, want 0/0 fs=1", s_x, s_y, s_fs);
    end
  endtask

  task automatic test_blink;
    int   nfs = 0, toggles = 0, t1 = -1, t2 = -1;
    logic prev;
    tick(1'b0, 1'b1);
    prev = s_blink;
    for (int c = 0; c < 66 * SHT * SVT; c++) begin
      tick(1'b0, 1'b0);
      if (s_fs === 1'b1) nfs++;
      if (s_blink !== prev) begin
        toggles++;
        if (toggles == 1) t1 = nfs;
        if (toggles == 2) t2 = nfs;
      end
      prev = s_blink;
    end
`ifdef VGA_BLINK_EN
    checks++;
    if (toggles != 2 || t1 != 32 || t2 != 64) begin
      errors++;
      $display("FAIL blink_period: got %0d toggles at frames %0d,%0d, want 2 at 32,64", toggles, t1, t2);
    end
`else
    checks++;
    if (toggles != 0 || s_blink !== 1'b0) begin
      errors++;
      $display("FAIL blink_tied: got %0d toggles blink=%b, want 0 toggles blink=0", toggles, s_blink);
    end
`endif
  endtask

  initial begin
    rst_f = 1'b1;
    rst_s = 1'b1;
    test_reset;
    test_line;
    test_mid_reset_full;
    test_frame;
    test_mid_reset_small;
    test_blink;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
